// File: rtl/in_service_control.sv
// In-service stage of an 8259A-style PIC: owns the ISR, raises INT, runs the
// two-pulse INTA sequence, emits the vector and applies EOI / automatic EOI.
module in_service_control #(
  parameter logic [4:0] RESET_VECTOR_BASE = 5'h08,
  parameter logic       RESET_AEOI        = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irr_masked,
  input  logic [2:0] resolved_interrupt,
  input  logic       inta_pulse,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       icw_load,
  input  logic [4:0] vector_base,
  input  logic       aeoi_en,
  output logic       int_out,
  output logic [7:0] irr_clear,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT2  = 2'd1;
  localparam logic [1:0] ST_VECTOR = 2'd2;

  logic [1:0] state;
  logic [2:0] ack_id;
  logic       spurious;
  logic [4:0] vector_base_reg;
  logic       aeoi_reg;
  logic [3:0] top;
  logic       pending;
  logic [7:0] isr_set;
  logic [7:0] isr_clr;

  // top = index of the highest-priority (lowest-numbered) in-service bit, 8 if none
  always_comb begin
    top = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (isr[i]) top = 4'(i);
    end
  end

  assign pending = (irr_masked != 8'h00) && ({1'b0, resolved_interrupt} < top);

  always_comb begin
    isr_set = 8'h00;
    isr_clr = 8'h00;
    if (state == ST_IDLE && inta_pulse && pending) isr_set[resolved_interrupt] = 1'b1;
    if (state == ST_VECTOR && aeoi_reg && !spurious) isr_clr[ack_id] = 1'b1;
    if (eoi_valid) begin
      if (eoi_specific) isr_clr[eoi_level] = 1'b1;
      else if (top != 4'd8) isr_clr[top[2:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      ack_id          <= 3'd0;
      spurious        <= 1'b0;
      vector_base_reg <= RESET_VECTOR_BASE;
      aeoi_reg        <= RESET_AEOI;
      int_out         <= 1'b0;
      irr_clear       <= 8'h00;
      isr             <= 8'h00;
      data_out        <= 8'h00;
      data_out_en     <= 1'b0;
    end else begin
      // set is applied after clear so a set on the same bit wins
      isr         <= (isr & ~isr_clr) | isr_set;
      irr_clear   <= 8'h00;
      data_out_en <= 1'b0;
      if (icw_load) begin
        vector_base_reg <= vector_base;
        aeoi_reg        <= aeoi_en;
      end
      case (state)
        ST_IDLE: begin
          if (inta_pulse) begin
            state     <= ST_WAIT2;
            int_out   <= 1'b0;
            ack_id    <= pending ? resolved_interrupt : 3'd7;
            spurious  <= !pending;
            irr_clear <= isr_set;
          end else begin
            int_out <= pending;
          end
        end
        ST_WAIT2: begin
          int_out <= 1'b0;
          if (inta_pulse) begin
            state       <= ST_VECTOR;
            data_out    <= {vector_base_reg, ack_id};
            data_out_en <= 1'b1;
          end
        end
        ST_VECTOR: begin
          int_out <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          int_out <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/in_service_control.md
# in_service_control

Downstream stage of `Priority_Resolver` in the 8259A-style PIC. It consumes the masked request vector and the resolver's winning IR index. It owns the In-Service Register (ISR) and decides when to raise INT to the CPU. It runs the two-pulse 8086-mode INTA sequence, emits the interrupt vector, and handles specific and non-specific EOI as well as automatic EOI (AEOI).

## Interface
Parameters:
- `RESET_VECTOR_BASE`, default 5'h08: value loaded into the vector-base register (T7..T3) on reset.
- `RESET_AEOI`, default 1'b0: AEOI mode after reset.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irr_masked`  in  8  IRR ANDed with ~IMR.
- `resolved_interrupt`  in  3  winning IR index from `Priority_Resolver`; meaningful only when `irr_masked != 0`.
- `inta_pulse`  in  1  one-cycle strobe per INTA falling edge, already synchronized upstream.
- `eoi_valid`  in  1  one-cycle EOI command strobe from the OCW2 decoder.
- `eoi_specific`  in  1  1 = specific EOI, 0 = non-specific; sampled with `eoi_valid`.
- `eoi_level`  in  3  IR to clear on specific EOI.
- `icw_load`  in  1  strobe; loads `vector_base` and `aeoi_en`.
- `vector_base`  in  5  T7..T3; sampled on `icw_load`.
- `aeoi_en`  in  1  AEOI mode; sampled on `icw_load`.
- `int_out`  out  1  INT request to the CPU; registered.
- `irr_clear`  out  8  one-hot, one-cycle pulse telling the IRR to drop the acknowledged bit.
- `isr`  out  8  current In-Service Register.
- `data_out`  out  8  interrupt vector.
- `data_out_en`  out  1  one-cycle strobe; `data_out` is valid while it is high.

## Operation
- Fixed nested priority: IR0 is highest. `top` is the lowest set ISR index, or 8 if the ISR is empty.
- `pending` = (`irr_masked != 0`) && (`resolved_interrupt < top`).
- State machine has three states: IDLE, WAIT2 and VECTOR.
  - In IDLE, `int_out` ← `pending`.
  - IDLE + `inta_pulse`:
    - Latch `ack_id`: `resolved_interrupt` if `pending` is 1 in that cycle, else 7 with the spurious flag set.
    - If not spurious, set ISR[`ack_id`] and drive `irr_clear` = 1<<`ack_id` for that one cycle (registered outputs, visible the next cycle).
    - Go to WAIT2.
  - WAIT2 + `inta_pulse`: go to VECTOR. `data_out` ← {vector_base_reg, ack_id} and `data_out_en` = 1 for exactly that one VECTOR cycle.
  - VECTOR: if AEOI is on and the request was not spurious, clear ISR[`ack_id`] on leaving. Then return to IDLE unconditionally.
  - `int_out` is 0 in WAIT2 and VECTOR. It is re-evaluated in the first IDLE cycle.
- EOI handling, accepted in any state:
  - Non-specific EOI clears ISR[`top`]. It has no effect if the ISR is empty.
  - Specific EOI clears ISR[`eoi_level`]. It has no effect if that bit is already 0.
- Simultaneous EOI and ISR set in the same cycle: both apply. On the same bit, set wins.
- `icw_load` in the same cycle as any other event: the new `vector_base` and `aeoi_en` values take effect from the next cycle. An in-flight `ack_id` is kept.
- `inta_pulse` in VECTOR is ignored.

## Timing
- Reset values:
  - `int_out` = 0, `irr_clear` = 0, `isr` = 8'h00, `data_out` = 8'h00, `data_out_en` = 0.
  - State = IDLE.
  - vector_base_reg = `RESET_VECTOR_BASE`, aeoi_reg = `RESET_AEOI`.
- `rst` mid-sequence (WAIT2 or VECTOR) abandons the cycle: no vector is emitted and the ISR is zeroed.
- Request to INT latency: `int_out` rises 1 cycle after `pending` becomes 1 while in IDLE.
- First `inta_pulse` at cycle N:
  - `isr` and `irr_clear` are updated at N+1.
  - `int_out` is 0 at N+1.
- Second `inta_pulse` at cycle M:
  - `data_out_en` = 1 at M+1 only.
  - With AEOI on, the ISR bit clears at M+2.
- EOI strobe at cycle N: ISR updated at N+1. `int_out` may reassert at N+2.
- Minimum spacing between INTA pulses is one cycle. Back-to-back pulses on consecutive cycles are legal.

## Test plan
- Basic ack sequence:
  - Setup: reset; `icw_load` with base 5'h08, AEOI 0; `irr_masked`=8'h04, resolved=2.
  - Required: `int_out`=1 one cycle later.
  - Two `inta_pulse`s → `irr_clear`=8'h04, `isr`=8'h04, `data_out`=8'h42 with a one-cycle `data_out_en`; `int_out` stays 0.
- Nesting:
  - ISR=8'h04; raise IR5 → `int_out` stays 0.
  - Raise IR1 → `int_out`=1.
  - Ack it → `isr`=8'h06.
  - Non-specific EOI → `isr`=8'h04.
- Specific EOI and the empty-ISR case:
  - ISR=8'h06, specific EOI with level 2 → `isr`=8'h02.
  - Non-specific EOI with an empty ISR → no change.
- Spurious request:
  - First `inta_pulse` while `irr_masked`=0 → ISR unchanged, `irr_clear`=0, vector = {base, 3'd7}.
- AEOI:
  - `aeoi_en`=1, ack IR3 → `isr` bit 3 high for two cycles, then 8'h00 two cycles after the second INTA.
  - Simultaneous EOI for IR3 on the first-INTA cycle of IR3 → bit 3 remains set.
- Reset in WAIT2 → `isr`=0, `data_out_en` never pulses, state IDLE, `int_out`=0.
